// File: rtl/kgp_mem_pkg.sv
// Shared types and defaults for the RISC_KGP unified-memory arbiter.
package kgp_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_t;

    localparam int MEM_LAT_DEF    = 1;
    localparam int MAX_STREAK_DEF = 4;

    // Data wins unless fetch has already been passed over MAX_STREAK times in a row.
    function automatic owner_t pick_owner(input logic if_req, input logic d_req,
                                          input logic at_limit);
        owner_t grant;
        grant = OWN_NONE;
        if (d_req && !(if_req && at_limit)) begin
            grant = OWN_D;
        end else if (if_req) begin
            grant = OWN_IF;
        end
        return grant;
    endfunction

endpackage

// File: rtl/kgp_mem_arbiter_if.sv
// Fetch, load/store and memory-macro signals of the unified-memory arbiter.
interface kgp_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic [DW-1:0] d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_done, if_rdata, d_done, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requesters plus memory macro side.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_done, if_rdata, d_done, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/kgp_mem_arbiter.sv
// Shares the single-port unified memory between fetch and load/store with an
// issue/wait/complete sequence, data priority and a bounded fetch-starvation streak.
module kgp_mem_arbiter
    import kgp_mem_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int MAX_STREAK = MAX_STREAK_DEF
) (
    input logic                clk,
    input logic                rst,
    kgp_mem_arbiter_if.slave   bus
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
    localparam int SW = $clog2(MAX_STREAK + 1);

    state_t         state, state_nxt;
    owner_t         owner, owner_nxt;
    logic [SW-1:0]  streak, streak_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           we_q, we_nxt;

    logic           mem_en_q, mem_en_nxt;
    logic           mem_we_q, mem_we_nxt;
    logic [AW-1:0]  mem_addr_q, mem_addr_nxt;
    logic [DW-1:0]  mem_wdata_q, mem_wdata_nxt;
    logic           if_done_q, if_done_nxt;
    logic           d_done_q, d_done_nxt;
    logic [DW-1:0]  if_rdata_q, if_rdata_nxt;
    logic [DW-1:0]  d_rdata_q, d_rdata_nxt;
    owner_t         grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            owner       <= OWN_NONE;
            streak      <= '0;
            cnt         <= '0;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            streak      <= streak_nxt;
            cnt         <= cnt_nxt;
            we_q        <= we_nxt;
            mem_en_q    <= mem_en_nxt;
            mem_we_q    <= mem_we_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
            if_done_q   <= if_done_nxt;
            d_done_q    <= d_done_nxt;
            if_rdata_q  <= if_rdata_nxt;
            d_rdata_q   <= d_rdata_nxt;
        end
    end

    // Every output is computed one cycle ahead so the port sees only flops.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        streak_nxt    = streak;
        cnt_nxt       = cnt;
        we_nxt        = we_q;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr_q;
        mem_wdata_nxt = mem_wdata_q;
        if_done_nxt   = 1'b0;
        d_done_nxt    = 1'b0;
        if_rdata_nxt  = if_rdata_q;
        d_rdata_nxt   = d_rdata_q;
        grant         = OWN_NONE;

        case (state)
            ST_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    grant      = pick_owner(bus.if_req, bus.d_req,
                                            streak == SW'(MAX_STREAK));
                    owner_nxt  = grant;
                    state_nxt  = ST_ISSUE;
                    mem_en_nxt = 1'b1;
                    if (grant == OWN_D) begin
                        we_nxt        = bus.d_we;
                        mem_we_nxt    = bus.d_we;
                        mem_addr_nxt  = bus.d_addr;
                        mem_wdata_nxt = bus.d_wdata;
                        if (!bus.if_req) begin
                            streak_nxt = '0;
                        end else if (streak != SW'(MAX_STREAK)) begin
                            streak_nxt = streak + SW'(1);
                        end
                    end else begin
                        we_nxt       = 1'b0;
                        mem_addr_nxt = bus.if_addr;
                        streak_nxt   = '0;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_nxt   = CW'(MEM_LAT - 1);
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_DONE;
                    if (owner == OWN_D) begin
                        d_done_nxt  = 1'b1;
                        d_rdata_nxt = we_q ? '0 : bus.mem_rdata;
                    end else begin
                        if_done_nxt  = 1'b1;
                        if_rdata_nxt = bus.mem_rdata;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                owner_nxt = OWN_NONE;
            end
            default: begin
                state_nxt = ST_IDLE;
                owner_nxt = OWN_NONE;
            end
        endcase
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_kgp_mem_arbiter.sv
// Directed bench for kgp_mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// each with a small behavioural memory that returns a poison word outside its data cycle.
module tb_kgp_mem_arbiter;

    localparam logic [31:0] POISON = 32'hBAD0BAD1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    kgp_mem_arbiter_if #(.AW(32), .DW(32)) b1 ();
    kgp_mem_arbiter_if #(.AW(32), .DW(32)) b3 ();

    kgp_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_STREAK(4)) u1 (
        .clk(clk), .rst(rst), .bus(b1));
    kgp_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .MAX_STREAK(4)) u3 (
        .clk(clk), .rst(rst), .bus(b3));

    // Memory for u1: read data present exactly one cycle after the mem_en cycle.
    logic [31:0] mem1 [0:255];
    logic [31:0] rd1;
    logic        rv1;
    always @(posedge clk) begin
        if (!rst) begin
            mem1[4] <= 32'hDEADBEEF;
            mem1[64] <= 32'h11110100;
            mem1[128] <= 32'h22220200;
            rv1 <= 1'b0;
            rd1 <= 32'h0;
        end else begin
            rv1 <= b1.mem_en && !b1.mem_we;
            rd1 <= mem1[b1.mem_addr[9:2]];
            if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr[9:2]] <= b1.mem_wdata;
        end
    end
    assign b1.mem_rdata = rv1 ? rd1 : POISON;

    // Memory for u3: three-stage read pipeline.
    logic [31:0] mem3 [0:255];
    logic [31:0] rd3 [0:2];
    logic        rv3 [0:2];
    always @(posedge clk) begin
        if (!rst) begin
            mem3[8] <= 32'h0BADC0DE;
            mem3[32] <= 32'hCAFEF00D;
            for (int i = 0; i < 3; i++) begin
                rv3[i] <= 1'b0;
                rd3[i] <= 32'h0;
            end
        end else begin
            rv3[0] <= b3.mem_en && !b3.mem_we;
            rd3[0] <= mem3[b3.mem_addr[9:2]];
            rv3[1] <= rv3[0];
            rd3[1] <= rd3[0];
            rv3[2] <= rv3[1];
            rd3[2] <= rd3[1];
            if (b3.mem_en && b3.mem_we) mem3[b3.mem_addr[9:2]] <= b3.mem_wdata;
        end
    end
    assign b3.mem_rdata = rv3[2] ? rd3[2] : POISON;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
        b3.if_req = 0; b3.if_addr = 0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = 0; b3.d_wdata = 0;
    endtask

    task automatic test_reset();
        int dones;
        idle_inputs();
        rst = 0;
        repeat (3) tick();
        checks++; if ({b1.if_done, b1.d_done, b1.mem_en, b1.mem_we} !== 4'b0) begin failures++; $display("FAIL rst_ctrl1 got=%b exp=0000", {b1.if_done, b1.d_done, b1.mem_en, b1.mem_we}); end
        checks++; if ({b1.if_rdata, b1.d_rdata, b1.mem_addr, b1.mem_wdata} !== 128'h0) begin failures++; $display("FAIL rst_data1 got=%h exp=0", {b1.if_rdata, b1.d_rdata, b1.mem_addr, b1.mem_wdata}); end
        checks++; if ({b3.if_done, b3.d_done, b3.mem_en, b3.mem_we} !== 4'b0) begin failures++; $display("FAIL rst_ctrl3 got=%b exp=0000", {b3.if_done, b3.d_done, b3.mem_en, b3.mem_we}); end
        rst = 1;
        tick();
        // Load on u3, then reset asynchronously in the middle of WAIT.
        b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h20;
        tick();
        checks++; if (b3.mem_en !== 1'b1 || b3.mem_addr !== 32'h20) begin failures++; $display("FAIL rst_pre_issue got=%b/%h exp=1/00000020", b3.mem_en, b3.mem_addr); end
        tick(); tick();
        rst = 0; b3.d_req = 0;
        #1;
        checks++; if ({b3.mem_en, b3.mem_we, b3.d_done, b3.mem_addr, b3.d_rdata} !== 67'h0) begin failures++; $display("FAIL rst_async got=%h exp=0", {b3.mem_en, b3.mem_we, b3.d_done, b3.mem_addr, b3.d_rdata}); end
        tick(); tick();
        rst = 1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (b3.d_done) dones++;
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", dones); end
        b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h20;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++; if (b3.d_done !== 1'b0) begin failures++; $display("FAIL rst_reload_early c=%0d got=%b exp=0", c, b3.d_done); end
        end
        tick();
        checks++; if (b3.d_done !== 1'b1 || b3.d_rdata !== 32'h0BADC0DE) begin failures++; $display("FAIL rst_reload got=%b/%h exp=1/0badc0de", b3.d_done, b3.d_rdata); end
        b3.d_req = 0;
        tick();
    endtask

    task automatic test_single_fetch();
        b1.if_req = 1; b1.if_addr = 32'h10;
        tick();
        checks++; if ({b1.mem_en, b1.mem_we} !== 2'b10 || b1.mem_addr !== 32'h10) begin failures++; $display("FAIL fetch_issue got=%b/%h exp=10/00000010", {b1.mem_en, b1.mem_we}, b1.mem_addr); end
        tick();
        checks++; if (b1.mem_en !== 1'b0 || b1.if_done !== 1'b0) begin failures++; $display("FAIL fetch_wait got=%b%b exp=00", b1.mem_en, b1.if_done); end
        tick();
        checks++; if (b1.if_done !== 1'b1 || b1.if_rdata !== 32'hDEADBEEF || b1.d_done !== 1'b0) begin failures++; $display("FAIL fetch_done got=%b/%h/%b exp=1/deadbeef/0", b1.if_done, b1.if_rdata, b1.d_done); end
        b1.if_req = 0;
        tick();
        checks++; if (b1.if_done !== 1'b0 || b1.if_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_hold got=%b/%h exp=0/deadbeef", b1.if_done, b1.if_rdata); end
    endtask

    task automatic test_store_load();
        b1.d_req = 1; b1.d_we = 1; b1.d_addr = 32'h40; b1.d_wdata = 32'h12345678;
        tick();
        checks++; if ({b1.mem_en, b1.mem_we} !== 2'b11 || b1.mem_addr !== 32'h40 || b1.mem_wdata !== 32'h12345678) begin failures++; $display("FAIL store_issue got=%b/%h/%h exp=11/00000040/12345678", {b1.mem_en, b1.mem_we}, b1.mem_addr, b1.mem_wdata); end
        tick();
        checks++; if ({b1.mem_en, b1.mem_we} !== 2'b00 || mem1[16] !== 32'h12345678) begin failures++; $display("FAIL store_write got=%b/%h exp=00/12345678", {b1.mem_en, b1.mem_we}, mem1[16]); end
        tick();
        checks++; if (b1.d_done !== 1'b1 || b1.d_rdata !== 32'h0) begin failures++; $display("FAIL store_done got=%b/%h exp=1/0", b1.d_done, b1.d_rdata); end
        b1.d_we = 0; b1.d_wdata = 32'hFFFFFFFF;
        tick();
        checks++; if (b1.d_done !== 1'b0 || b1.mem_en !== 1'b0) begin failures++; $display("FAIL load_idle got=%b%b exp=00", b1.d_done, b1.mem_en); end
        tick();
        checks++; if ({b1.mem_en, b1.mem_we} !== 2'b10 || b1.mem_addr !== 32'h40) begin failures++; $display("FAIL load_issue got=%b/%h exp=10/00000040", {b1.mem_en, b1.mem_we}, b1.mem_addr); end
        tick(); tick();
        checks++; if (b1.d_done !== 1'b1 || b1.d_rdata !== 32'h12345678) begin failures++; $display("FAIL load_done got=%b/%h exp=1/12345678", b1.d_done, b1.d_rdata); end
        b1.d_req = 0;
        tick();
    endtask

    task automatic test_simultaneous();
        b1.if_req = 1; b1.if_addr = 32'h10;
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h40;
        tick();
        checks++; if (b1.mem_en !== 1'b1 || b1.mem_addr !== 32'h40) begin failures++; $display("FAIL sim_first got=%b/%h exp=1/00000040", b1.mem_en, b1.mem_addr); end
        tick(); tick();
        checks++; if ({b1.d_done, b1.if_done} !== 2'b10 || b1.d_rdata !== 32'h12345678) begin failures++; $display("FAIL sim_d_done got=%b/%h exp=10/12345678", {b1.d_done, b1.if_done}, b1.d_rdata); end
        b1.d_req = 0;
        tick(); tick();
        checks++; if (b1.mem_en !== 1'b1 || b1.mem_addr !== 32'h10) begin failures++; $display("FAIL sim_second got=%b/%h exp=1/00000010", b1.mem_en, b1.mem_addr); end
        tick(); tick();
        checks++; if ({b1.d_done, b1.if_done} !== 2'b01 || b1.if_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sim_if_done got=%b/%h exp=01/deadbeef", {b1.d_done, b1.if_done}, b1.if_rdata); end
        b1.if_req = 0;
        tick();
    endtask

    task automatic test_starvation();
        int   n;
        int   both_done;
        int   en_twice;
        logic prev_en;
        logic grants [0:9];
        logic expected [0:9];
        expected = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        n = 0; both_done = 0; en_twice = 0; prev_en = 1'b0;
        b1.if_req = 1; b1.if_addr = 32'h100;
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h200;
        for (int c = 0; c < 60 && n < 10; c++) begin
            tick();
            if (b1.if_done && b1.d_done) both_done++;
            if (b1.mem_en && prev_en) en_twice++;
            prev_en = b1.mem_en;
            if (b1.mem_en) begin
                grants[n] = (b1.mem_addr == 32'h100);
                n++;
            end
        end
        b1.if_req = 0; b1.d_req = 0;
        checks++; if (n !== 10) begin failures++; $display("FAIL starve_count got=%0d exp=10", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (grants[i] !== expected[i]) begin failures++; $display("FAIL starve_grant%0d got_if=%b exp_if=%b", i, grants[i], expected[i]); end
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            if (b1.if_done && b1.d_done) both_done++;
            if (b1.mem_en && prev_en) en_twice++;
            prev_en = b1.mem_en;
        end
        checks++; if (both_done !== 0) begin failures++; $display("FAIL done_overlap got=%0d exp=0", both_done); end
        checks++; if (en_twice !== 0) begin failures++; $display("FAIL mem_en_back_to_back got=%0d exp=0", en_twice); end
    endtask

    task automatic test_latency3();
        b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h80;
        tick();
        checks++; if (b3.mem_en !== 1'b1 || b3.mem_addr !== 32'h80) begin failures++; $display("FAIL lat3_issue got=%b/%h exp=1/00000080", b3.mem_en, b3.mem_addr); end
        for (int c = 2; c <= 4; c++) begin
            tick();
            checks++; if (b3.d_done !== 1'b0 || b3.mem_en !== 1'b0) begin failures++; $display("FAIL lat3_wait c=%0d got=%b%b exp=00", c, b3.d_done, b3.mem_en); end
        end
        tick();
        checks++; if (b3.d_done !== 1'b1 || b3.d_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL lat3_done got=%b/%h exp=1/cafef00d", b3.d_done, b3.d_rdata); end
        b3.d_req = 0;
        tick();
        checks++; if (b3.d_done !== 1'b0) begin failures++; $display("FAIL lat3_pulse got=%b exp=0", b3.d_done); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_load();
        test_simultaneous();
        test_starvation();
        test_latency3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
